// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared timing constants and period meter state encoding
package period_meter_pkg;

    localparam int unsigned PIX_CLK_HZ     = 25175000;
    localparam int unsigned ONE_SECOND_CYC = PIX_CLK_HZ;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } pm_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-stage synchroniser with registered-level edge detection
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkIn,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   level_d;

    always_ff @(posedge clkIn) begin
        if (rst) begin
            sync    <= '0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], din};
            level_d <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow input in clkIn cycles
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned F_OSC       = PIX_CLK_HZ,
    parameter int unsigned TIMEOUT_CYC = F_OSC,
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic             sigIn,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] highTime,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

    pm_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, hcnt;
    logic             hcnt_run;
    logic             level, rise, fall;
    logic             load, tmo, slot_free;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clkIn (clkIn),
        .rst   (rst),
        .din   (sigIn),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clkIn) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // A rise landing on the timeout cycle completes the period instead of timing out.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        tmo        = 1'b0;
        case (state)
            ST_IDLE: if (enable) state_next = ST_ARM;
            ST_ARM: begin
                if (!enable)   state_next = ST_IDLE;
                else if (rise) state_next = ST_MEAS;
            end
            ST_MEAS: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (rise) begin
                    load = 1'b1;
                end else if (cnt == TMO) begin
                    tmo        = 1'b1;
                    state_next = ST_ARM;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign timeout = tmo;

    // hcnt_run closes the high window at the falling edge so hcnt freezes until the next rise.
    always_ff @(posedge clkIn) begin
        if (rst || state_next != ST_MEAS) begin
            cnt      <= '0;
            hcnt     <= '0;
            hcnt_run <= 1'b0;
        end else if (rise) begin
            cnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
            hcnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
            hcnt_run <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            if (hcnt_run && !fall) hcnt <= hcnt + 1'b1;
            if (fall)              hcnt_run <= 1'b0;
        end
    end

    assign slot_free = !valid || ready;

    always_ff @(posedge clkIn) begin
        if (rst) begin
            period   <= '0;
            highTime <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else if (load && slot_free) begin
            period   <= cnt;
            highTime <= hcnt;
            valid    <= 1'b1;
        end else begin
            if (load)          overrun <= 1'b1;
            if (valid && ready) valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter
module tb_period_meter;
    import period_meter_pkg::*;

    logic       clkIn = 1'b0;
    logic       rst, sigIn, enable, ready;
    logic [7:0] period, highTime;
    logic       valid, overrun, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc_idx, n_acc, first_acc, last_acc, n_tmo, first_tmo;
    logic [7:0] last_p, last_h;
    int         p_q[$];
    int         h_q[$];

    period_meter #(
        .F_OSC       (100),
        .TIMEOUT_CYC (100),
        .CNT_W       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clkIn    (clkIn),
        .rst      (rst),
        .sigIn    (sigIn),
        .enable   (enable),
        .period   (period),
        .highTime (highTime),
        .valid    (valid),
        .ready    (ready),
        .overrun  (overrun),
        .timeout  (timeout)
    );

    always #5 clkIn = ~clkIn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc_idx = 0; n_acc = 0; first_acc = 0; last_acc = 0;
        n_tmo = 0; first_tmo = 0; last_p = '0; last_h = '0;
        p_q.delete(); h_q.delete();
    endtask

    task automatic cyc(input logic s);
        sigIn = s;
        @(posedge clkIn);
        #1;
        cyc_idx++;
        if (valid && ready) begin
            n_acc++;
            if (n_acc == 1) first_acc = cyc_idx;
            last_acc = cyc_idx;
            last_p = period;
            last_h = highTime;
            p_q.push_back(int'(period));
            h_q.push_back(int'(highTime));
        end
        if (timeout) begin
            n_tmo++;
            if (n_tmo == 1) first_tmo = cyc_idx;
        end
    endtask

    task automatic wave(input int hi, input int lo);
        for (int i = 0; i < hi; i++) cyc(1'b1);
        for (int i = 0; i < lo; i++) cyc(1'b0);
    endtask

    initial begin
        rst = 1'b1; sigIn = 1'b0; enable = 1'b0; ready = 1'b0;
        clear_mon();
        cyc(1'b0);
        cyc(1'b0);
        check("rst_period", period, 0);
        check("rst_high", highTime, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", dut.state, ST_IDLE);
        rst = 1'b0;

        // steady 10/4 wave, consumer always ready
        enable = 1'b1; ready = 1'b1;
        clear_mon();
        for (int w = 0; w < 4; w++) wave(4, 6);
        check("t1_count", n_acc, 3);
        check("t1_first", first_acc, 13);
        check("t1_last", last_acc, 33);
        foreach (p_q[i]) check("t1_period", p_q[i], 10);
        foreach (h_q[i]) check("t1_high", h_q[i], 4);
        check("t1_tmo", n_tmo, 0);

        // consumer stalls across three rises
        ready = 1'b0;
        clear_mon();
        wave(4, 6);
        check("t2_valid_first", valid, 1);
        check("t2_ovr_first", overrun, 0);
        wave(4, 6);
        wave(4, 6);
        check("t2_valid", valid, 1);
        check("t2_period", period, 10);
        check("t2_high", highTime, 4);
        check("t2_overrun", overrun, 1);
        ready = 1'b1;
        cyc(1'b0);
        check("t2_valid_clr", valid, 0);
        check("t2_ovr_sticky", overrun, 1);
        enable = 1'b0;
        cyc(1'b0);
        cyc(1'b0);

        // single rise then silence -> timeout, then a 20-cycle period
        enable = 1'b1;
        clear_mon();
        for (int i = 0; i < 4; i++) cyc(1'b1);
        for (int i = 0; i < 120; i++) cyc(1'b0);
        check("t3_tmo_count", n_tmo, 1);
        check("t3_tmo_at", first_tmo, 102);
        check("t3_no_valid", n_acc, 0);
        check("t3_state", dut.state, ST_ARM);
        clear_mon();
        wave(5, 15);
        wave(5, 15);
        check("t3_count", n_acc, 1);
        check("t3_first", first_acc, 23);
        check("t3_period", last_p, 20);
        check("t3_high", last_h, 5);

        // enable drops mid-measurement with a result pending
        ready = 1'b0;
        clear_mon();
        for (int i = 0; i < 4; i++) cyc(1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0);
        check("t4_cnt5", dut.cnt, 5);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0);
        check("t4_state", dut.state, ST_IDLE);
        check("t4_valid", valid, 1);
        check("t4_period", period, 20);
        check("t4_high", highTime, 5);
        check("t4_tmo", n_tmo, 0);
        ready = 1'b1;
        cyc(1'b0);
        check("t4_consumed", valid, 0);
        enable = 1'b1;
        clear_mon();
        wave(4, 6);
        check("t4_one_rise", n_acc, 0);
        wave(4, 6);
        check("t4_two_rise", n_acc, 1);
        check("t4_period2", last_p, 10);
        check("t4_high2", last_h, 4);

        // reset while a result is pending and overrun is set
        ready = 1'b0;
        clear_mon();
        wave(4, 6);
        check("t5_pre_valid", valid, 1);
        check("t5_pre_ovr", overrun, 1);
        rst = 1'b1;
        cyc(1'b0);
        check("t5_valid", valid, 0);
        check("t5_overrun", overrun, 0);
        check("t5_period", period, 0);
        check("t5_high", highTime, 0);
        check("t5_state", dut.state, ST_IDLE);
        rst = 1'b0;

        // rises exactly TIMEOUT_CYC apart: result wins over timeout
        ready = 1'b1;
        clear_mon();
        wave(10, 90);
        wave(10, 90);
        check("t6_count", n_acc, 1);
        check("t6_first", first_acc, 103);
        check("t6_period", last_p, 100);
        check("t6_high", last_h, 10);
        check("t6_tmo", n_tmo, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
